// File: rtl/evaluate_collect.sv
// evaluate_collect: initiator side of the evaluator handshake. Fans a latched board out to
// NUM_EVAL evaluators, gathers their mg/eg terms and returns one phase-tapered signed score.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module evaluate_collect #(
   parameter int EVAL_WIDTH = 24,
   parameter int NUM_EVAL   = 4,
   parameter int TIMEOUT    = 63
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [`BOARD_WIDTH-1:0]        board_in,
   input  logic [8:0]                     phase_in,
   output logic                           busy,
   output logic [`BOARD_WIDTH-1:0]        board,
   output logic                           board_valid,
   output logic                           clear_eval,
   input  logic [NUM_EVAL*EVAL_WIDTH-1:0] eval_mg_in,
   input  logic [NUM_EVAL*EVAL_WIDTH-1:0] eval_eg_in,
   input  logic [NUM_EVAL-1:0]            eval_valid_in,
   output logic [EVAL_WIDTH-1:0]          result,
   output logic                           result_error,
   output logic                           result_valid,
   input  logic                           result_ready,
   output logic [2:0]                     state_dbg
);
   localparam int SW = EVAL_WIDTH + 4;
   localparam int TW = SW + 11;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic signed [TW-1:0] SAT_MAX = {{(TW-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
   localparam logic signed [TW-1:0] SAT_MIN = {{(TW-EVAL_WIDTH+1){1'b1}}, {(EVAL_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_ASSERT, S_WAIT, S_SUM, S_TAPER, S_OUT, S_RECOVER} state_t;
   state_t state, state_next;

   logic [NUM_EVAL-1:0]   captured, captured_now;
   logic [EVAL_WIDTH-1:0] held_mg [NUM_EVAL];
   logic [EVAL_WIDTH-1:0] held_eg [NUM_EVAL];
   logic [CW-1:0]         wait_cnt;
   logic                  recover_cnt;
   logic [8:0]            phase;
   logic signed [SW-1:0]  mg_sum, eg_sum, mg_acc, eg_acc;
   logic signed [TW-1:0]  mg_ext, eg_ext, ph_ext, ph_inv_ext, t_full, t_shift;
   logic [EVAL_WIDTH-1:0] sat_val;
   logic                  all_now, timeout_now;

   // Result handshake: result/result_error are valid while result_valid=1 and are consumed on
   // the cycle result_ready=1; ready while result_valid=0 is ignored.
   assign captured_now = captured | eval_valid_in;
   assign all_now      = &captured_now;
   assign timeout_now  = (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start) state_next = S_ASSERT;
         S_ASSERT:  state_next = S_WAIT;
         S_WAIT:    if (all_now || timeout_now) state_next = S_SUM;
         S_SUM:     state_next = S_TAPER;
         S_TAPER:   state_next = S_OUT;
         S_OUT:     if (result_ready) state_next = S_RECOVER;
         S_RECOVER: if (recover_cnt) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != S_IDLE);
      state_dbg = state;
   end

   always_comb begin
      mg_acc = '0;
      eg_acc = '0;
      for (int i = 0; i < NUM_EVAL; i++) begin
         mg_acc = mg_acc + {{4{held_mg[i][EVAL_WIDTH-1]}}, held_mg[i]};
         eg_acc = eg_acc + {{4{held_eg[i][EVAL_WIDTH-1]}}, held_eg[i]};
      end
   end

   // Phase is at most 256, so both weights are non-negative and zero-extend safely.
   always_comb begin
      mg_ext     = {{11{mg_sum[SW-1]}}, mg_sum};
      eg_ext     = {{11{eg_sum[SW-1]}}, eg_sum};
      ph_ext     = {{(TW-9){1'b0}}, phase};
      ph_inv_ext = {{(TW-9){1'b0}}, 9'd256 - phase};
      t_full     = mg_ext * ph_ext + eg_ext * ph_inv_ext;
      t_shift    = t_full >>> 8;
      if (t_shift > SAT_MAX)      sat_val = {1'b0, {(EVAL_WIDTH-1){1'b1}}};
      else if (t_shift < SAT_MIN) sat_val = {1'b1, {(EVAL_WIDTH-1){1'b0}}};
      else                        sat_val = t_shift[EVAL_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         board        <= '0;
         board_valid  <= 1'b0;
         clear_eval   <= 1'b0;
         result       <= '0;
         result_error <= 1'b0;
         result_valid <= 1'b0;
         captured     <= '0;
         wait_cnt     <= '0;
         recover_cnt  <= 1'b0;
         phase        <= '0;
         mg_sum       <= '0;
         eg_sum       <= '0;
         for (int i = 0; i < NUM_EVAL; i++) begin
            held_mg[i] <= '0;
            held_eg[i] <= '0;
         end
      end else begin
         clear_eval <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               board        <= board_in;
               phase        <= (phase_in > 9'd256) ? 9'd256 : phase_in;
               captured     <= '0;
               wait_cnt     <= '0;
               result_error <= 1'b0;
               board_valid  <= 1'b1;
               for (int i = 0; i < NUM_EVAL; i++) begin
                  held_mg[i] <= '0;
                  held_eg[i] <= '0;
               end
            end
            S_WAIT: begin
               captured <= captured_now;
               for (int i = 0; i < NUM_EVAL; i++) begin
                  if (eval_valid_in[i] && !captured[i]) begin
                     held_mg[i] <= eval_mg_in[i*EVAL_WIDTH +: EVAL_WIDTH];
                     held_eg[i] <= eval_eg_in[i*EVAL_WIDTH +: EVAL_WIDTH];
                  end
               end
               if (all_now) begin
                  clear_eval  <= 1'b1;
                  board_valid <= 1'b0;
               end else if (timeout_now) begin
                  result_error <= 1'b1;
                  clear_eval   <= 1'b1;
                  board_valid  <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            S_SUM: begin
               mg_sum <= mg_acc;
               eg_sum <= eg_acc;
            end
            S_TAPER: begin
               result       <= sat_val;
               result_valid <= 1'b1;
            end
            S_OUT: if (result_ready) begin
               result_valid <= 1'b0;
               recover_cnt  <= 1'b0;
            end
            S_RECOVER: recover_cnt <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/evaluate_collect.md
Name: evaluate_collect

Overview:
- Initiator side of the evaluator handshake.
- Latches a board from the search controller and presents it to NUM_EVAL parallel evaluators (pawn, material, mobility, and so on).
- Waits for every evaluator's eval_valid, sums the mg/eg terms, tapers them by game phase, and returns one signed score.
- Closes each evaluation with clear_eval, then enforces a recovery gap so the evaluators' stale eval_valid is never sampled.

Parameters:
- EVAL_WIDTH, 24, width of each evaluator term and of the result.
- NUM_EVAL, 4, number of attached evaluators (1..16).
- TIMEOUT, 63, maximum WAIT cycles before an error completion.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new evaluation; accepted only in IDLE.
- board_in  in  `BOARD_WIDTH  board sampled on the accepted start.
- phase_in  in  9  game phase, 0 = endgame, 256 = opening; sampled with board_in.
- busy  out  1  high in every state except IDLE.
- board  out  `BOARD_WIDTH  latched board, fanned out to the evaluators.
- board_valid  out  1  level; the evaluators trigger on its rising edge.
- clear_eval  out  1  single-cycle release of all evaluators.
- eval_mg_in  in  NUM_EVAL*EVAL_WIDTH  packed signed mg terms, evaluator i at [i*EVAL_WIDTH+:EVAL_WIDTH].
- eval_eg_in  in  NUM_EVAL*EVAL_WIDTH  packed signed eg terms.
- eval_valid_in  in  NUM_EVAL  per-evaluator valid, level, held until clear_eval.
- result  out  EVAL_WIDTH  signed tapered score.
- result_error  out  1  set when the evaluation timed out.
- result_valid  out  1  held high until result_ready.
- result_ready  in  1  consumer acknowledge.

Behaviour:
- Reset: state=IDLE; board_valid, clear_eval, busy, result_valid and result_error are 0; result=0; captured flags=0. Reset mid-operation aborts immediately and does not pulse clear_eval. The evaluators share the same reset.
- States are IDLE, ASSERT, WAIT, SUM, TAPER, OUT, RECOVER.
- IDLE:
  - On start=1, latch board_in into board.
  - Latch phase_in clamped to 256.
  - Clear the captured flags and the timeout counter; go to ASSERT.
  - start in any other state is ignored.
- ASSERT (1 cycle): board_valid<=1; go to WAIT. board is stable from the cycle after start until RECOVER exits.
- WAIT:
  - Each cycle, captured[i] |= eval_valid_in[i]. On each newly set flag, latch that evaluator's mg/eg into a holding register.
  - When all NUM_EVAL flags are set (including flags set in the same cycle): clear_eval<=1 for exactly one cycle, board_valid<=0, go to SUM.
  - If the counter reaches TIMEOUT first: result_error<=1, uncaptured terms are treated as 0, clear_eval pulses, board_valid<=0, go to SUM.
- SUM:
  - mg_sum and eg_sum are the signed sums of the held terms at width EVAL_WIDTH+4, with no overflow at that width.
- TAPER:
  - t = mg_sum*phase + eg_sum*(256-phase), signed, full width.
  - Then t >>> 8, arithmetic shift (floor toward -inf).
- OUT:
  - result <= tapered value saturated to [-2^(EVAL_WIDTH-1), 2^(EVAL_WIDTH-1)-1].
  - result_valid<=1; hold result, result_error and result_valid until result_ready=1.
  - On that cycle, result_valid<=0 and go to RECOVER.
  - result_ready while result_valid=0 has no effect.
- RECOVER: 2 cycles with board_valid=0, then IDLE. result_error is cleared on the next accepted start.
- Recovery rationale: an evaluator drops eval_valid two cycles after sampling clear_eval and needs board_valid low to see a fresh rising edge.
- Latency:
  - Let k be the cycle in which the last flag sets.
  - clear_eval is high in cycle k+1.
  - result_valid is high from cycle k+3.
  - With ideal evaluators of latency 7, the accepted start at cycle 0 gives board_valid high at cycle 1.
- Each evaluator's eval_valid is sampled only in WAIT, so the first term is never taken before ASSERT has completed.

Test Plan:
- NUM_EVAL=2, phase=256, mg terms {100,-30}, eg terms {5,5}, both valid 7 cycles after board_valid -> result=70, error=0, exactly one clear_eval pulse, result_valid 3 cycles after the last valid.
- phase=0, mg {100,-30}, eg {40,-50} -> result=-10; phase=128 -> (70*128 + -10*128)>>>8 = 30; mg sum -3, eg sum 0, phase=128 -> -2 (floor).
- Evaluator 0 valid at cycle 3, evaluator 1 valid at cycle 9 (staggered) -> both terms captured, clear_eval only after cycle 9, single pulse.
- Evaluator 1 never valid, TIMEOUT=63 -> clear_eval at WAIT cycle 63, result_error=1, result equals the evaluator-0 term only.
- result_ready held low 10 cycles -> result and result_valid stable; start pulses ignored (busy=1); after ready, board_valid stays 0 for 2 cycles before the next start is accepted.
- Saturation: EVAL_WIDTH=8, mg {127,127}, phase=256 -> result=127; reset asserted mid-WAIT -> all outputs 0 next cycle, no clear_eval pulse.
